// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the three channels around the instruction fetch queue.
//   PC channel      : pc_in, pc_valid (to queue), pc_ready (from queue)
//   Memory request  : imem_req_valid, imem_req_addr (from queue), imem_req_ready (to queue)
//   Memory response : imem_rsp_valid, imem_rsp_data (to queue, always accepted)
//   Redirect        : flush (to queue)
//   Decode channel  : q_valid, q_instr, q_pc (from queue), q_ready (to queue)
// slave  = the fetch queue itself, master = everything around it.
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              flush;
    logic              q_valid;
    logic [DATA_W-1:0] q_instr;
    logic [ADDR_W-1:0] q_pc;
    logic              q_ready;

    modport slave (
        input  pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               flush, q_ready,
        output pc_ready, imem_req_valid, imem_req_addr, q_valid, q_instr, q_pc
    );

    modport master (
        output pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               flush, q_ready,
        input  pc_ready, imem_req_valid, imem_req_addr, q_valid, q_instr, q_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the program counter and decode.
// Issues PC addresses to instruction memory, accepts in-order responses of any
// latency, and buffers {pc, instr} pairs in a DEPTH-slot ring for decode.
// A flush discards buffered entries and arranges for in-flight responses to
// be dropped when they eventually return.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_queue_if.slave (PC, memory request/response, flush, decode)
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_queue_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PW-1:0]     r_alloc_ptr;
    logic [PW-1:0]     r_fill_ptr;
    logic [PW-1:0]     r_head_ptr;
    logic [CW-1:0]     r_used;
    logic [CW-1:0]     r_drop_cnt;

    logic [CW:0]       w_occ;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_pop;
    logic              w_rsp_drop;
    logic              w_rsp_fill;
    logic [CW-1:0]     w_filled_cnt;
    logic [CW-1:0]     w_unfilled;
    logic [CW-1:0]     w_drop_nxt;

    // Credit counts slots still owed to dropped responses, so the memory
    // never holds more than DEPTH outstanding requests. Registered values only.
    assign w_occ    = {1'b0, r_used} + {1'b0, r_drop_cnt};
    assign w_credit = w_occ < (CW+1)'(DEPTH);

    assign bus.imem_req_valid = bus.pc_valid && w_credit && !bus.flush;
    assign bus.imem_req_addr  = bus.pc_in;
    assign bus.pc_ready       = bus.imem_req_ready && w_credit && !bus.flush;
    assign w_req_fire         = bus.pc_valid && bus.pc_ready;

    assign bus.q_valid = r_filled[r_head_ptr] && !bus.flush;
    assign bus.q_pc    = r_pc[r_head_ptr];
    assign bus.q_instr = r_instr[r_head_ptr];
    assign w_pop       = bus.q_valid && bus.q_ready;

    assign w_rsp_drop = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill = bus.imem_rsp_valid && (r_drop_cnt == '0);

    always_comb begin
        w_filled_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + CW'(r_filled[i]);
        end
    end

    assign w_unfilled = r_used - w_filled_cnt;

    // On flush every allocated-but-unfilled slot still has a response coming;
    // a response landing in the flush cycle itself is already one of those.
    always_comb begin
        if (bus.flush) begin
            w_drop_nxt = r_drop_cnt + w_unfilled - CW'(bus.imem_rsp_valid);
        end else begin
            w_drop_nxt = r_drop_cnt - CW'(w_rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_used      <= '0;
            r_drop_cnt  <= '0;
        end else if (bus.flush) begin
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_used      <= '0;
            r_drop_cnt  <= w_drop_nxt;
        end else begin
            // Alloc, fill and head slots are always distinct when each fires,
            // so the three filled-bit updates never collide.
            if (w_req_fire) begin
                r_pc[r_alloc_ptr]     <= bus.pc_in;
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + 1'b1;
            end
            if (w_rsp_fill) begin
                r_instr[r_fill_ptr]  <= bus.imem_rsp_data;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + 1'b1;
            end
            if (w_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
                r_head_ptr           <= r_head_ptr + 1'b1;
            end
            r_used     <= r_used + CW'(w_req_fire) - CW'(w_pop);
            r_drop_cnt <= w_drop_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Response source: table rows drive tb_rsp_*, the latency model drives mdl_rsp_*.
    logic          mem_auto = 1'b0;
    logic          tb_rsp_valid = 1'b0;
    logic [DW-1:0] tb_rsp_data  = '0;
    logic          mdl_rsp_valid = 1'b0;
    logic [DW-1:0] mdl_rsp_data  = '0;
    assign bus.imem_rsp_valid = mem_auto ? mdl_rsp_valid : tb_rsp_valid;
    assign bus.imem_rsp_data  = mem_auto ? mdl_rsp_data  : tb_rsp_data;

    int unsigned mem_lat = 1;
    int unsigned cyc     = 0;

    function automatic logic [31:0] f_instr(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // In-order memory with fixed latency
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    mreq_t       mq[$];
    logic        m_hs;
    logic        m_fire;
    logic [31:0] m_addr;

    initial begin
        forever begin
            @(negedge clk);
            m_hs   = bus.imem_req_valid && bus.imem_req_ready && rst_n;
            m_addr = bus.imem_req_addr;
            m_fire = mdl_rsp_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                mq.delete();
                mdl_rsp_valid = 1'b0;
            end else begin
                if (m_fire && mq.size() > 0) void'(mq.pop_front());
                if (m_hs) mq.push_back('{addr: m_addr, due: cyc + mem_lat - 1});
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    mdl_rsp_valid = 1'b1;
                    mdl_rsp_data  = f_instr(mq[0].addr);
                end else begin
                    mdl_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Stimulus state and scoreboard
    int          issue_lim = 0;
    int          n_issued  = 0;
    int          n_popped  = 0;
    int          outst     = 0;
    logic [31:0] next_pc   = '0;
    bit          rr_rand   = 1'b0;
    bit          qr_rand   = 1'b0;
    bit          qr_val    = 1'b0;
    bit          flush_req = 1'b0;
    bit          sb_on     = 1'b0;
    logic [63:0] sb[$];

    task automatic drive();
        bus.pc_valid       = (n_issued < issue_lim);
        bus.pc_in          = next_pc;
        bus.imem_req_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.q_ready        = qr_rand ? 1'($urandom_range(0, 1)) : qr_val;
        bus.flush          = flush_req;
    endtask

    task automatic finish_cycle();
        logic [63:0] e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            outst = 0;
        end else begin
            if (bus.imem_rsp_valid) begin
                chk("rsp_has_outstanding_req", outst > 0, 1);
                if (outst > 0) outst--;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) outst++;
            if (bus.flush) begin
                sb.delete();
            end else if (sb_on && bus.q_valid && bus.q_ready) begin
                n_popped++;
                chk("pop_has_expected_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_q_pc", bus.q_pc, e[63:32]);
                    chk("sb_q_instr", bus.q_instr, e[31:0]);
                end
            end
            if (bus.pc_valid && bus.pc_ready) begin
                n_issued++;
                if (sb_on) sb.push_back({bus.pc_in, f_instr(bus.pc_in)});
                next_pc = next_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        drive();
        finish_cycle();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        tb_rsp_valid = 1'b0;
        tb_rsp_data  = '0;
        flush_req    = 1'b0;
        issue_lim    = 0;
        rr_rand      = 1'b0;
        qr_rand      = 1'b0;
        qr_val       = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_issued = 0;
        n_popped = 0;
        outst    = 0;
        sb.delete();
    endtask

    task automatic wait_head(input string tag, input logic [31:0] pc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive();
            #2;
            if (bus.q_valid) begin
                got = 1'b1;
                chk({tag, "_q_pc"}, bus.q_pc, pc);
                chk({tag, "_q_instr"}, bus.q_instr, f_instr(pc));
            end
            finish_cycle();
        end
        chk({tag, "_delivered"}, got, 1);
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        fl;
        logic        qr;
        logic        e_prdy;
        logic        e_rqv;
        logic        e_qv;
        logic [31:0] e_qpc;
        logic [31:0] e_qi;
        logic        cd;
    } vec_t;

    localparam logic [31:0] I0 = 32'h0000_0013;
    localparam logic [31:0] I4 = 32'h0040_0093;
    localparam logic [31:0] I8 = 32'h0080_0113;

    vec_t tbl[9];

    initial begin
        //        pv    pc           rr    rv    rd    fl    qr    prdy  rqv   qv    qpc         qi    cd
        tbl[0] = '{1'b1, 32'h0,       1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,     '0,   1'b1};
        tbl[1] = '{1'b1, 32'h4,       1'b1, 1'b1, I0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,     '0,   1'b1};
        tbl[2] = '{1'b1, 32'h8,       1'b1, 1'b1, I4,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,     I0,   1'b1};
        tbl[3] = '{1'b0, 32'h0,       1'b1, 1'b1, I8,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4,     I4,   1'b1};
        tbl[4] = '{1'b0, 32'h0,       1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8,     I8,   1'b1};
        tbl[5] = '{1'b0, 32'h0,       1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     '0,   1'b1};
        tbl[6] = '{1'b1, 32'hC,       1'b0, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,     '0,   1'b0};
        tbl[7] = '{1'b1, 32'hC,       1'b1, 1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     '0,   1'b0};
        tbl[8] = '{1'b0, 32'h0,       1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     '0,   1'b0};

        // Async reset: outputs while rst_n is low
        #1;
        rst_n = 1'b0;
        drive();
        bus.pc_valid = 1'b1;
        #1;
        chk("rst_pc_ready", bus.pc_ready, 1);
        chk("rst_req_valid", bus.imem_req_valid, 1);
        chk("rst_q_valid", bus.q_valid, 0);
        chk("rst_q_pc", bus.q_pc, 0);
        chk("rst_q_instr", bus.q_instr, 0);
        do_reset();

        // Directed table: stream 0x0, 0x4, 0x8 with a 1-cycle memory
        mem_auto = 1'b0;
        sb_on    = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.pc_valid       = tbl[k].pv;
            bus.pc_in          = tbl[k].pc;
            bus.imem_req_ready = tbl[k].rr;
            tb_rsp_valid       = tbl[k].rv;
            tb_rsp_data        = tbl[k].rd;
            bus.flush          = tbl[k].fl;
            bus.q_ready        = tbl[k].qr;
            #2;
            chk($sformatf("v%0d_pc_ready", k), bus.pc_ready, tbl[k].e_prdy);
            chk($sformatf("v%0d_req_valid", k), bus.imem_req_valid, tbl[k].e_rqv);
            chk($sformatf("v%0d_req_addr", k), bus.imem_req_addr, tbl[k].pc);
            chk($sformatf("v%0d_q_valid", k), bus.q_valid, tbl[k].e_qv);
            if (tbl[k].cd) begin
                chk($sformatf("v%0d_q_pc", k), bus.q_pc, tbl[k].e_qpc);
                chk($sformatf("v%0d_q_instr", k), bus.q_instr, tbl[k].e_qi);
            end
            finish_cycle();
        end
        tb_rsp_valid = 1'b0;

        // Full queue, then drain; freed slot is usable the cycle after the pop
        do_reset();
        mem_auto  = 1'b1;
        mem_lat   = 1;
        sb_on     = 1'b1;
        issue_lim = 6;
        next_pc   = 32'h40;
        repeat (8) tick();
        chk("full_handshakes", n_issued, 4);
        drive();
        #2;
        chk("full_pc_ready", bus.pc_ready, 0);
        chk("full_req_valid", bus.imem_req_valid, 0);
        chk("full_q_valid", bus.q_valid, 1);
        finish_cycle();
        qr_val = 1'b1;
        drive();
        #2;
        chk("pop_cycle_pc_ready", bus.pc_ready, 0);
        chk("pop_cycle_q_pc", bus.q_pc, 32'h40);
        finish_cycle();
        drive();
        #2;
        chk("after_pop_pc_ready", bus.pc_ready, 1);
        finish_cycle();
        chk("fifth_accepted", n_issued, 5);
        for (int i = 0; i < 30 && n_popped < 6; i++) tick();
        chk("full_drained", n_popped, 6);
        chk("full_sb_empty", sb.size(), 0);

        // Flush with two fetches in flight on a 3-cycle memory
        do_reset();
        mem_lat   = 3;
        qr_val    = 1'b1;
        issue_lim = 2;
        next_pc   = 32'h10;
        tick();
        tick();
        chk("inflight_issued", n_issued, 2);
        flush_req = 1'b1;
        issue_lim = 3;
        next_pc   = 32'h100;
        drive();
        #2;
        chk("flush_pc_ready", bus.pc_ready, 0);
        chk("flush_req_valid", bus.imem_req_valid, 0);
        chk("flush_q_valid", bus.q_valid, 0);
        finish_cycle();
        flush_req = 1'b0;
        wait_head("redirect", 32'h100);
        repeat (8) tick();
        chk("redirect_pops", n_popped, 1);

        // Flush coinciding with a response and a would-be pop
        do_reset();
        mem_lat   = 1;
        qr_val    = 1'b0;
        issue_lim = 2;
        next_pc   = 32'h200;
        tick();
        tick();
        flush_req = 1'b1;
        qr_val    = 1'b1;
        issue_lim = 3;
        next_pc   = 32'h300;
        drive();
        #2;
        chk("flpop_q_valid", bus.q_valid, 0);
        chk("flpop_pc_ready", bus.pc_ready, 0);
        finish_cycle();
        flush_req = 1'b0;
        chk("flpop_no_pop", n_popped, 0);
        wait_head("after_flpop", 32'h300);
        repeat (6) tick();
        chk("after_flpop_pops", n_popped, 1);

        // Wrap-around with random backpressure on both sides
        do_reset();
        mem_lat   = 2;
        rr_rand   = 1'b1;
        qr_rand   = 1'b1;
        issue_lim = 10;
        next_pc   = 32'h1000;
        for (int i = 0; i < 300 && n_popped < 10; i++) tick();
        chk("wrap_pops", n_popped, 10);
        chk("wrap_issued", n_issued, 10);
        chk("wrap_sb_empty", sb.size(), 0);
        rr_rand = 1'b0;
        qr_rand = 1'b0;

        // Reset mid-stream with 3 buffered entries
        do_reset();
        mem_lat   = 1;
        qr_val    = 1'b0;
        issue_lim = 3;
        next_pc   = 32'h2000;
        repeat (5) tick();
        drive();
        #2;
        chk("pre_rst_q_valid", bus.q_valid, 1);
        chk("pre_rst_q_pc", bus.q_pc, 32'h2000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_q_valid", bus.q_valid, 0);
        chk("async_rst_q_pc", bus.q_pc, 0);
        chk("async_rst_pc_ready", bus.pc_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_issued  = 0;
        n_popped  = 0;
        outst     = 0;
        sb.delete();
        issue_lim = 5;
        next_pc   = 32'h3000;
        repeat (8) tick();
        chk("post_rst_handshakes", n_issued, 4);
        qr_val = 1'b1;
        for (int i = 0; i < 30 && n_popped < 5; i++) tick();
        chk("post_rst_drained", n_popped, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
